// File: rtl/music_pkg.sv
// Shared definitions for the play-command trigger: FSM encoding and song timing defaults.
package music_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [7:0]  PLAY_CMD_DEFAULT = 8'h48;
    localparam logic [31:0] BEAT_CYCLES      = 32'd12_500_000;
    localparam logic [7:0]  SONG_BEATS       = 8'd71;
    localparam logic [31:0] LOCKOUT_DEFAULT  = 32'(BEAT_CYCLES * 32'(SONG_BEATS));

endpackage

// File: rtl/music_trigger_cycle_timer.sv
// Loadable 32-bit down-counter shared by the HOLD and LOCK phases.
module cycle_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        run,
    output logic        done
);

    logic [31:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 32'd0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != 32'd0)) begin
            count <= count - 32'd1;
        end
    end

    assign done = run && (count == 32'd0);

endmodule

// File: rtl/music_trigger.sv
// Turns play-command bytes into a stretched start level with a song-length lockout,
// one optional queued repeat and a saturating count of dropped requests.
//
//   state   | meaning
//   IDLE    | waiting for a play request
//   HOLD    | start held high for START_HOLD_CYCLES
//   LOCK    | remainder of the song, start low, busy high
module music_trigger
    import music_pkg::*;
#(
    parameter logic [7:0]  PLAY_CMD          = PLAY_CMD_DEFAULT,
    parameter logic [31:0] START_HOLD_CYCLES = 32'd25_000_000,
    parameter logic [31:0] LOCKOUT_CYCLES    = LOCKOUT_DEFAULT,
    parameter logic        QUEUE_EN          = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       enable,
    output logic       start,
    output logic       busy,
    output logic [7:0] dropped_cnt
);

    localparam logic [31:0] HOLD_LOAD = START_HOLD_CYCLES - 32'd1;
    localparam logic [31:0] LOCK_LOAD = LOCKOUT_CYCLES - START_HOLD_CYCLES - 32'd1;

    state_t      state, state_next;
    logic        pending, pending_next;
    logic        drop_inc;
    logic        tmr_load;
    logic [31:0] tmr_load_val;
    logic        tmr_done;
    logic        play;
    logic        can_queue;

    assign play      = rx_valid && (rx_data == PLAY_CMD);
    assign can_queue = QUEUE_EN && enable;

    cycle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .run      (state != ST_IDLE),
        .done     (tmr_done)
    );

    always_comb begin
        state_next   = state;
        pending_next = pending;
        drop_inc     = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = 32'd0;

        case (state)
            ST_IDLE: begin
                if (play && enable) begin
                    state_next   = ST_HOLD;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                end
            end

            ST_HOLD: begin
                if (play) begin
                    if (can_queue && !pending) pending_next = 1'b1;
                    else                       drop_inc     = 1'b1;
                end
                if (tmr_done) begin
                    state_next   = ST_LOCK;
                    tmr_load     = 1'b1;
                    tmr_load_val = LOCK_LOAD;
                end
            end

            ST_LOCK: begin
                if (tmr_done) begin
                    // A request landing on the terminal cycle is judged against the old pending.
                    pending_next = 1'b0;
                    if (enable && pending) begin
                        state_next   = ST_HOLD;
                        tmr_load     = 1'b1;
                        tmr_load_val = HOLD_LOAD;
                        drop_inc     = play;
                    end else if (play && can_queue) begin
                        state_next   = ST_HOLD;
                        tmr_load     = 1'b1;
                        tmr_load_val = HOLD_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                        drop_inc   = play;
                    end
                end else if (play) begin
                    if (can_queue && !pending) pending_next = 1'b1;
                    else                       drop_inc     = 1'b1;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            dropped_cnt <= 8'd0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            start   <= (state_next == ST_HOLD);
            busy    <= (state_next != ST_IDLE);
            if (drop_inc && (dropped_cnt != 8'hFF)) begin
                dropped_cnt <= dropped_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_music_trigger.sv
// Directed checks of music_trigger with short hold/lockout timing.
module tb_music_trigger;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       enable = 1'b1;
    logic       start, busy;
    logic [7:0] dropped_cnt;
    logic       start_nq, busy_nq;
    logic [7:0] dropped_nq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    music_trigger #(
        .PLAY_CMD(8'h48), .START_HOLD_CYCLES(32'd4), .LOCKOUT_CYCLES(32'd20), .QUEUE_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .enable(enable),
        .start(start), .busy(busy), .dropped_cnt(dropped_cnt)
    );

    // No-queue instance with a long lockout so 300 requests fit inside one song.
    music_trigger #(
        .PLAY_CMD(8'h48), .START_HOLD_CYCLES(32'd4), .LOCKOUT_CYCLES(32'd400), .QUEUE_EN(1'b0)
    ) dut_nq (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .enable(enable),
        .start(start_nq), .busy(busy_nq), .dropped_cnt(dropped_nq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        enable   = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_drop",  32'(dropped_cnt), 32'd0);
    endtask

    // Runs ncyc cycles; play requests at cycles r0..r2 (-1 = none), enable low from en_off.
    // Expected start windows [s0a,s0b] and [s1a,s1b], busy window [ba,bb] (-1 = none).
    task automatic run_seq(input string tag, input int ncyc,
                           input int r0, input int r1, input int r2, input int en_off,
                           input int s0a, input int s0b, input int s1a, input int s1b,
                           input int ba, input int bb, input int exp_drop);
        logic es, eb;
        for (int c = 0; c < ncyc; c++) begin
            es = ((c >= s0a) && (c <= s0b) && (s0a >= 0)) || ((c >= s1a) && (c <= s1b) && (s1a >= 0));
            eb = (c >= ba) && (c <= bb) && (ba >= 0);
            chk({tag, "_start"}, 32'(start), 32'(es));
            chk({tag, "_busy"},  32'(busy),  32'(eb));
            rx_valid = (c == r0) || (c == r1) || (c == r2);
            rx_data  = 8'h48;
            enable   = !((en_off >= 0) && (c >= en_off));
            tick();
        end
        rx_valid = 1'b0;
        enable   = 1'b1;
        chk({tag, "_drop"}, 32'(dropped_cnt), 32'(exp_drop));
    endtask

    initial begin
        #2;
        do_reset();

        run_seq("single", 35, 10, -1, -1, -1, 11, 14, -1, -1, 11, 30, 0);

        begin
            logic [7:0] bytes [4];
            bytes = '{8'h41, 8'h00, 8'hFF, 8'h48};
            for (int i = 0; i < 4; i++) begin
                rx_data  = bytes[i];
                rx_valid = (i < 3);
                tick();
                rx_valid = 1'b0;
                tick();
                chk("nonplay_start", 32'(start), 32'd0);
                chk("nonplay_busy",  32'(busy),  32'd0);
            end
        end

        do_reset();
        run_seq("queue", 55, 10, 15, 18, -1, 11, 14, 31, 34, 11, 50, 1);

        do_reset();
        run_seq("term_pend0", 55, 10, 30, -1, -1, 11, 14, 31, 34, 11, 50, 0);

        do_reset();
        run_seq("term_pend1", 55, 10, 15, 30, -1, 11, 14, 31, 34, 11, 50, 1);

        do_reset();
        run_seq("en_idle", 20, 5, -1, -1, 0, -1, -1, -1, -1, -1, -1, 0);

        do_reset();
        run_seq("en_lock", 40, 10, 15, -1, 20, 11, 14, -1, -1, 11, 30, 0);

        do_reset();
        for (int c = 0; c <= 305; c++) begin
            if (c == 101) chk("sat_100", 32'(dropped_nq), 32'd100);
            if (c == 256) chk("sat_255", 32'(dropped_nq), 32'hFF);
            if (c == 301) begin
                chk("sat_hold", 32'(dropped_nq), 32'hFF);
                chk("sat_busy", 32'(busy_nq), 32'd1);
            end
            rx_valid = (c <= 300);
            rx_data  = 8'h48;
            tick();
        end
        rx_valid = 1'b0;
        chk("sat_final", 32'(dropped_nq), 32'hFF);

        do_reset();
        for (int c = 0; c < 13; c++) begin
            rx_valid = (c == 10) || (c == 11) || (c == 12);
            rx_data  = 8'h48;
            tick();
        end
        rx_valid = 1'b0;
        chk("pre_rst_start", 32'(start), 32'd1);
        chk("pre_rst_drop",  32'(dropped_cnt), 32'd1);
        reset = 1'b1;
        #2;
        chk("async_start", 32'(start), 32'd0);
        chk("async_busy",  32'(busy),  32'd0);
        chk("async_drop",  32'(dropped_cnt), 32'd0);
        tick();
        reset = 1'b0;
        run_seq("post_rst", 35, 10, -1, -1, -1, 11, 14, -1, -1, 11, 30, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
